mem_port_arbiter: RTL

Shares one unified single-port block-RAM port between the instruction-fetch stage and the MEM-stage load/store path. It grants at most one requester per cycle, with data priority and bounded fetch starvation. It drives the RAM port and routes read data back to its owner with a fixed-latency valid strobe. It lets the core replace its separate instruction ROM and data RAM with one shared memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/resp_tag_pipe.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - owner codes, default parameters and tag helper for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_IF    = 2'd1,
      OWN_DLOAD = 2'd2
   } owner_e;

   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 4;
   localparam int STARVE_W       = 4;

   // A redirect makes any in-flight fetch response stale; load tags are untouched
   function automatic owner_e flush_kill(owner_e tag, logic flush);
      return (flush && (tag == OWN_IF)) ? OWN_NONE : tag;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM port bundle for the memory port arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 12
);
   logic              i_IfReq_1;
   logic [31:0]       i_IfAddr_32;
   logic              i_Flush_1;
   logic              o_IfGnt_1;
   logic              o_IfValid_1;
   logic [31:0]       o_IfData_32;
   logic              i_DReq_1;
   logic              i_DWe_1;
   logic [31:0]       i_DAddr_32;
   logic [31:0]       i_DWData_32;
   logic [3:0]        i_DByteEn_4;
   logic              o_DGnt_1;
   logic              o_DValid_1;
   logic [31:0]       o_DRData_32;
   logic              o_MemEn_1;
   logic [3:0]        o_MemWe_4;
   logic [ADDR_W-1:0] o_MemAddr;
   logic [31:0]       o_MemWData_32;
   logic [31:0]       i_MemRData_32;

   modport slave (
      input  i_IfReq_1, i_IfAddr_32, i_Flush_1,
      input  i_DReq_1, i_DWe_1, i_DAddr_32, i_DWData_32, i_DByteEn_4,
      input  i_MemRData_32,
      output o_IfGnt_1, o_IfValid_1, o_IfData_32,
      output o_DGnt_1, o_DValid_1, o_DRData_32,
      output o_MemEn_1, o_MemWe_4, o_MemAddr, o_MemWData_32
   );

   modport master (
      output i_IfReq_1, i_IfAddr_32, i_Flush_1,
      output i_DReq_1, i_DWe_1, i_DAddr_32, i_DWData_32, i_DByteEn_4,
      output i_MemRData_32,
      input  o_IfGnt_1, o_IfValid_1, o_IfData_32,
      input  o_DGnt_1, o_DValid_1, o_DRData_32,
      input  o_MemEn_1, o_MemWe_4, o_MemAddr, o_MemWData_32
   );

endinterface

// File: rtl/resp_tag_pipe.sv
// rtl/resp_tag_pipe.sv - fixed-depth owner tag shift register with fetch flush-kill
module resp_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = DEF_MEM_LAT
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  owner_e push_tag,
   output owner_e out_tag
);

   owner_e tag_q [DEPTH];
   owner_e tag_d [DEPTH];

   // Advance tags one stage; the tag entering this cycle is never killed by the current flush
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         tag_d[i] = OWN_NONE;
      end
      tag_d[0] = push_tag;
      for (int i = 1; i < DEPTH; i++) begin
         tag_d[i] = flush_kill(tag_q[i-1], flush);
      end
   end

   // Tag storage; reset discards every in-flight response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= OWN_NONE;
         end
      end else begin
         tag_q <= tag_d;
      end
   end

   assign out_tag = flush_kill(tag_q[DEPTH-1], flush);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between instruction fetch and load/store
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic                if_gnt;
   logic                d_gnt;
   logic [STARVE_W-1:0] starve_cnt_q;
   logic [STARVE_W-1:0] starve_cnt_d;
   logic                mem_en;
   logic [3:0]          mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [31:0]         mem_wdata;
   owner_e              push_tag;
   owner_e              out_tag;
   logic                if_valid;
   logic                d_valid;
   logic [ADDR_W-1:0]   if_word;
   logic [ADDR_W-1:0]   d_word;
   logic                unused_addr_bits;

   assign if_word = bus.i_IfAddr_32[ADDR_W+1:2];
   assign d_word  = bus.i_DAddr_32[ADDR_W+1:2];
   assign unused_addr_bits = ^{bus.i_IfAddr_32[31:ADDR_W+2], bus.i_IfAddr_32[1:0],
                               bus.i_DAddr_32[31:ADDR_W+2], bus.i_DAddr_32[1:0]};

   // Data has priority until fetch has waited STARVE_MAX data grants; nothing is granted in reset
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (bus.i_IfReq_1 && (!bus.i_DReq_1 || (starve_cnt_q >= STARVE_LIM))) begin
            if_gnt = 1'b1;
         end else if (bus.i_DReq_1) begin
            d_gnt = 1'b1;
         end
      end
   end

   // Count data grants that overtook a waiting fetch, saturating at the limit
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.i_IfReq_1 || if_gnt) begin
         starve_cnt_d = '0;
      end else if (d_gnt && (starve_cnt_q < STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Steer the granted request onto the RAM port and pick the owner tag of its response
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      push_tag  = OWN_NONE;
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = d_word;
         mem_wdata = bus.i_DWData_32;
         if (bus.i_DWe_1) begin
            mem_we = bus.i_DByteEn_4;
         end else begin
            push_tag = OWN_DLOAD;
         end
      end else if (if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_word;
         push_tag = OWN_IF;
      end
   end

   resp_tag_pipe #(
      .DEPTH (MEM_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.i_Flush_1),
      .push_tag (push_tag),
      .out_tag  (out_tag)
   );

   assign if_valid = (out_tag == OWN_IF);
   assign d_valid  = (out_tag == OWN_DLOAD);

   assign bus.o_IfGnt_1     = if_gnt;
   assign bus.o_DGnt_1      = d_gnt;
   assign bus.o_MemEn_1     = mem_en;
   assign bus.o_MemWe_4     = mem_we;
   assign bus.o_MemAddr     = mem_addr;
   assign bus.o_MemWData_32 = mem_wdata;
   assign bus.o_IfValid_1   = if_valid;
   assign bus.o_IfData_32   = if_valid ? bus.i_MemRData_32 : 32'h0;
   assign bus.o_DValid_1    = d_valid;
   assign bus.o_DRData_32   = d_valid ? bus.i_MemRData_32 : 32'h0;

endmodule
